nyq_ups: RTL

NYQ_UPS -- requirements
Module: nyq_ups

---
 rtl/nyq_ups.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/nyq_ups.sv
// Upsampler feeding a Nyquist filter: emits one FIFO symbol per L-cycle period, zero-stuffed.
// Optional NYQ_UPS_HOLD_EN adds a config bit selecting zero-order hold instead of zero-stuffing.
module nyq_ups #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MEM_WIDTH  = 24,
    parameter int unsigned IN_WIDTH   = 24,
    parameter int unsigned OUT_WIDTH  = 24,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] CFG_ADDR = ADDR_WIDTH'(11'h7FF)
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  WrEn_SI,
    input  logic [ADDR_WIDTH-1:0] Addr_DI,
    input  logic [MEM_WIDTH-1:0]  PAR_In_DI,
    input  logic [IN_WIDTH-1:0]   Sym_In_DI,
    input  logic                  Sym_Valid_SI,
    output logic                  Sym_Ready_SO,
    output logic [OUT_WIDTH-1:0]  UPS_Out_DO,
    output logic                  UPS_Valid_SO,
    output logic                  Underrun_SO
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(FIFO_DEPTH);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);

    logic [IN_WIDTH-1:0]  fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [3:0]           l_q, l_d, l_act_q, l_act_d, p_q, p_d, l_cur;
    logic                 run_q, run_d;
    logic [OUT_WIDTH-1:0] out_q, out_d, held;
    logic                 valid_q, valid_d, und_q, und_d;
    logic                 cfg_wr, push, pop, phase0, und_ev, hold_mode;
    logic                 unused_par;

`ifdef NYQ_UPS_HOLD_EN
    logic                 hold_q, hold_d;
    logic [OUT_WIDTH-1:0] held_q, held_d;
    assign hold_mode = hold_q;
    assign held      = held_q;
`else
    assign hold_mode = 1'b0;
    assign held      = '0;
`endif

    assign unused_par   = ^PAR_In_DI[MEM_WIDTH-1:6];
    assign Sym_Ready_SO = (cnt_q < DepthC);
    assign UPS_Out_DO   = out_q;
    assign UPS_Valid_SO = valid_q;
    assign Underrun_SO  = und_q;

    always_comb begin
        cfg_wr  = WrEn_SI && (Addr_DI == CFG_ADDR);
        push    = Sym_Valid_SI && Sym_Ready_SO;
        phase0  = run_q && (p_q == 4'd0);
        pop     = phase0 && (cnt_q != '0);
        // A pending L only governs the period that starts on a phase-0 cycle.
        l_cur   = phase0 ? l_q : l_act_q;
        l_d     = l_q;
        run_d   = run_q;
        l_act_d = phase0 ? l_q : l_act_q;
        p_d     = 4'd0;
        out_d   = '0;
        valid_d = 1'b0;
        und_ev  = 1'b0;
`ifdef NYQ_UPS_HOLD_EN
        hold_d  = hold_q;
        held_d  = held_q;
`endif
        if (cfg_wr) begin
            l_d   = (PAR_In_DI[3:0] == 4'd0) ? 4'd1 : PAR_In_DI[3:0];
            run_d = PAR_In_DI[4];
`ifdef NYQ_UPS_HOLD_EN
            hold_d = PAR_In_DI[6];
`endif
        end
        if (run_q) begin
            p_d = ((p_q + 4'd1) == l_cur) ? 4'd0 : p_q + 4'd1;
            if (phase0) begin
                if (pop) begin
                    out_d   = OUT_WIDTH'($signed(fifo_q[rd_ptr_q]));
                    valid_d = 1'b1;
                end else begin
                    und_ev = 1'b1;
                end
`ifdef NYQ_UPS_HOLD_EN
                held_d = out_d;
`endif
            end else if (hold_mode) begin
                out_d = held;
            end
        end
        und_d    = (und_q && !(cfg_wr && PAR_In_DI[5])) || und_ev;
        wr_ptr_d = push ? ((wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop ? ((rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
        cnt_d    = cnt_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge Clk_CI) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= Sym_In_DI;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            l_q      <= 4'd4;
            l_act_q  <= 4'd4;
            p_q      <= 4'd0;
            run_q    <= 1'b0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            und_q    <= 1'b0;
`ifdef NYQ_UPS_HOLD_EN
            hold_q   <= 1'b0;
            held_q   <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            l_q      <= l_d;
            l_act_q  <= l_act_d;
            p_q      <= p_d;
            run_q    <= run_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            und_q    <= und_d;
`ifdef NYQ_UPS_HOLD_EN
            hold_q   <= hold_d;
            held_q   <= held_d;
`endif
        end
    end

endmodule
